// File: rtl/axi4lite_to_pi1_pkg.sv
// Shared PI1 definitions for the AXI4-Lite to PI1 bridge.
//   - PI1 operation encodings (PINOOP/PIWROP/PIRDOP/PIRWOP)
//   - clog2 helper used to size word addresses
//   - bridge FSM state type
package axi4lite_to_pi1_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    function automatic int clog2(input int value);
        return $clog2(value);
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_WAIT,
        S_BRESP,
        S_RRESP
    } state_t;

endpackage

// File: rtl/axi4lite_to_pi1_if.sv
// Bus bundle for the AXI4-Lite to PI1 bridge.
//   - AXI4-Lite AW/W/B/AR/R channels (bridge is the AXI slave)
//   - PI1 op/addr/data/sel/rdy (bridge is the PI1 master)
// Modports:
//   slave  : the bridge's view (AXI inputs, PI1 outputs)
//   master : the environment's view (drives AXI requests, PI1 slave replies)
interface axi4lite_to_pi1_if
    import axi4lite_to_pi1_pkg::*;
#(
    parameter int ARCHBITSZ = 32
);
    localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);
    localparam int SELBITSZ  = ARCHBITSZ / 8;

    logic [ARCHBITSZ-1:0] axi4_awaddr_i;
    logic                 axi4_awvalid_i;
    logic                 axi4_awready_o;
    logic [ARCHBITSZ-1:0] axi4_wdata_i;
    logic [SELBITSZ-1:0]  axi4_wstrb_i;
    logic                 axi4_wvalid_i;
    logic                 axi4_wready_o;
    logic [1:0]           axi4_bresp_o;
    logic                 axi4_bvalid_o;
    logic                 axi4_bready_i;
    logic [ARCHBITSZ-1:0] axi4_araddr_i;
    logic                 axi4_arvalid_i;
    logic                 axi4_arready_o;
    logic [ARCHBITSZ-1:0] axi4_rdata_o;
    logic [1:0]           axi4_rresp_o;
    logic                 axi4_rvalid_o;
    logic                 axi4_rready_i;

    logic [1:0]           pi1_op_o;
    logic [ADDRBITSZ-1:0] pi1_addr_o;
    logic [ARCHBITSZ-1:0] pi1_data_o;
    logic [ARCHBITSZ-1:0] pi1_data_i;
    logic [SELBITSZ-1:0]  pi1_sel_o;
    logic                 pi1_rdy_i;

    modport slave (
        input  axi4_awaddr_i, axi4_awvalid_i,
        output axi4_awready_o,
        input  axi4_wdata_i, axi4_wstrb_i, axi4_wvalid_i,
        output axi4_wready_o,
        output axi4_bresp_o, axi4_bvalid_o,
        input  axi4_bready_i,
        input  axi4_araddr_i, axi4_arvalid_i,
        output axi4_arready_o,
        output axi4_rdata_o, axi4_rresp_o, axi4_rvalid_o,
        input  axi4_rready_i,
        output pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o,
        input  pi1_data_i, pi1_rdy_i
    );

    modport master (
        output axi4_awaddr_i, axi4_awvalid_i,
        input  axi4_awready_o,
        output axi4_wdata_i, axi4_wstrb_i, axi4_wvalid_i,
        input  axi4_wready_o,
        input  axi4_bresp_o, axi4_bvalid_o,
        output axi4_bready_i,
        output axi4_araddr_i, axi4_arvalid_i,
        input  axi4_arready_o,
        input  axi4_rdata_o, axi4_rresp_o, axi4_rvalid_o,
        output axi4_rready_i,
        input  pi1_op_o, pi1_addr_o, pi1_data_o, pi1_sel_o,
        output pi1_data_i, pi1_rdy_i
    );

endinterface

// File: rtl/axi4lite_to_pi1.sv
// AXI4-Lite slave that turns each AXI read or write into exactly one PI1
// master transaction. One transaction in flight, responses always OKAY.
// Ports:
//   clk_i : clock, all logic on the rising edge
//   rst_i : asynchronous active-high reset
//   bus   : AXI4-Lite slave channels + PI1 master signals (slave modport)
module axi4lite_to_pi1
    import axi4lite_to_pi1_pkg::*;
#(
    parameter int ARCHBITSZ = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    axi4lite_to_pi1_if.slave bus
);
    localparam int SELBITSZ  = ARCHBITSZ / 8;
    localparam int LSB       = clog2(SELBITSZ);
    localparam int ADDRBITSZ = ARCHBITSZ - LSB;

    state_t               state_reg, state_next;
    logic                 aw_got_reg, aw_got_next;
    logic                 w_got_reg, w_got_next;
    logic                 rd_pri_reg, rd_pri_next;   // 1: read wins the next contention
    logic [ADDRBITSZ-1:0] addr_reg, addr_next;
    logic [ARCHBITSZ-1:0] wdata_reg, wdata_next;
    logic [SELBITSZ-1:0]  sel_reg, sel_next;
    logic [ARCHBITSZ-1:0] rdata_reg, rdata_next;

    logic in_idle;
    logic wr_req;
    logic ar_ok;
    logic contention;
    logic aw_hs, w_hs, ar_hs;

    // Byte offsets within a word are dropped; no narrow/unaligned splitting.
    logic unused_lsbs;
    assign unused_lsbs = ^{bus.axi4_awaddr_i[LSB-1:0], bus.axi4_araddr_i[LSB-1:0]};

    assign in_idle = (state_reg == S_IDLE) && !rst_i;
    assign wr_req  = bus.axi4_awvalid_i || bus.axi4_wvalid_i;
    // A read may only start when no half-captured write is pending, so a
    // contention only exists while both write flags are still clear.
    assign ar_ok      = !aw_got_reg && !w_got_reg;
    assign contention = bus.axi4_arvalid_i && wr_req && ar_ok;

    assign bus.axi4_arready_o = in_idle && ar_ok && bus.axi4_arvalid_i
                                && (!wr_req || rd_pri_reg);
    assign bus.axi4_awready_o = in_idle && !aw_got_reg && bus.axi4_awvalid_i
                                && !(contention && rd_pri_reg);
    assign bus.axi4_wready_o  = in_idle && !w_got_reg && bus.axi4_wvalid_i
                                && !(contention && rd_pri_reg);

    assign aw_hs = bus.axi4_awvalid_i && bus.axi4_awready_o;
    assign w_hs  = bus.axi4_wvalid_i  && bus.axi4_wready_o;
    assign ar_hs = bus.axi4_arvalid_i && bus.axi4_arready_o;

    always_comb begin
        state_next  = state_reg;
        aw_got_next = aw_got_reg;
        w_got_next  = w_got_reg;
        rd_pri_next = rd_pri_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        sel_next    = sel_reg;
        rdata_next  = rdata_reg;

        case (state_reg)
            S_IDLE: begin
                if (contention) begin
                    rd_pri_next = !rd_pri_reg;
                end
                if (aw_hs) begin
                    aw_got_next = 1'b1;
                    addr_next   = bus.axi4_awaddr_i[ARCHBITSZ-1:LSB];
                end
                if (w_hs) begin
                    w_got_next = 1'b1;
                    wdata_next = bus.axi4_wdata_i;
                    sel_next   = bus.axi4_wstrb_i;
                end
                if (ar_hs) begin
                    addr_next  = bus.axi4_araddr_i[ARCHBITSZ-1:LSB];
                    sel_next   = '1;
                    state_next = S_RD_ISSUE;
                end else if (aw_got_next && w_got_next) begin
                    // An all-zero strobe writes nothing, so skip the PI1 op.
                    state_next = (sel_next == '0) ? S_BRESP : S_WR_ISSUE;
                end
            end
            S_WR_ISSUE, S_RD_ISSUE: begin
                if (bus.pi1_rdy_i) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.pi1_rdy_i) begin
                    // Write flags stay set for the whole write, so a clear
                    // aw flag here means the op in flight is a read.
                    if (aw_got_reg) begin
                        state_next = S_BRESP;
                    end else begin
                        rdata_next = bus.pi1_data_i;
                        state_next = S_RRESP;
                    end
                end
            end
            S_BRESP: begin
                if (bus.axi4_bready_i) begin
                    aw_got_next = 1'b0;
                    w_got_next  = 1'b0;
                    state_next  = S_IDLE;
                end
            end
            S_RRESP: begin
                if (bus.axi4_rready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= S_IDLE;
            aw_got_reg <= 1'b0;
            w_got_reg  <= 1'b0;
            rd_pri_reg <= 1'b1;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            sel_reg    <= '0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            aw_got_reg <= aw_got_next;
            w_got_reg  <= w_got_next;
            rd_pri_reg <= rd_pri_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            sel_reg    <= sel_next;
            rdata_reg  <= rdata_next;
        end
    end

    // Op decodes straight from state so an asynchronous reset forces NOOP
    // in the same cycle.
    assign bus.pi1_op_o   = (state_reg == S_WR_ISSUE) ? PIWROP :
                            (state_reg == S_RD_ISSUE) ? PIRDOP : PINOOP;
    assign bus.pi1_addr_o = addr_reg;
    assign bus.pi1_data_o = wdata_reg;
    assign bus.pi1_sel_o  = sel_reg;

    assign bus.axi4_bvalid_o = (state_reg == S_BRESP);
    assign bus.axi4_bresp_o  = 2'b00;
    assign bus.axi4_rvalid_o = (state_reg == S_RRESP);
    assign bus.axi4_rresp_o  = 2'b00;
    assign bus.axi4_rdata_o  = rdata_reg;

endmodule

// File: doc/axi4lite_to_pi1.md
# axi4lite_to_pi1

- AXI4-Lite slave that turns each AXI read or write into one PI1 master transaction.
- Placement: between an AXI-side initiator (debug bridge, DMA, soft-core port) and the internal PI1 fabric, on the same `clk_i` domain.
- Scope: one transaction in flight, no bursts.
- Responses: always OKAY; PI1 carries no error signalling.

## Interface
- ARCHBITSZ, 32, data width in bits (16/32/64/128); ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8)
- clk_i  in  1  clock; all logic on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- axi4_awaddr_i  in  ARCHBITSZ  write byte address
- axi4_awvalid_i / axi4_awready_o  in / out  1 each  AW handshake
- axi4_wdata_i  in  ARCHBITSZ  write data
- axi4_wstrb_i  in  ARCHBITSZ/8  byte strobes
- axi4_wvalid_i / axi4_wready_o  in / out  1 each  W handshake
- axi4_bresp_o  out  2  always 2'b00
- axi4_bvalid_o / axi4_bready_i  out / in  1 each  B handshake
- axi4_araddr_i  in  ARCHBITSZ  read byte address
- axi4_arvalid_i / axi4_arready_o  in / out  1 each  AR handshake
- axi4_rdata_o  out  ARCHBITSZ  read data
- axi4_rresp_o  out  2  always 2'b00
- axi4_rvalid_o / axi4_rready_i  out / in  1 each  R handshake
- pi1_op_o  out  2  NOOP=00, WR=01, RD=10 (RW=11 never issued)
- pi1_addr_o  out  ADDRBITSZ  word address = byte address [ARCHBITSZ-1 : clog2(ARCHBITSZ/8)]
- pi1_data_o  out  ARCHBITSZ  write data
- pi1_data_i  in  ARCHBITSZ  read data, valid on the completion cycle
- pi1_sel_o  out  ARCHBITSZ/8  byte select: wstrb for writes, all-ones for reads
- pi1_rdy_i  in  1  PI1 slave ready

## Operation
**States:** IDLE, WR_ISSUE, RD_ISSUE, WAIT, BRESP, RRESP.

**IDLE**
- AW and W are captured independently, in either order or together; flags aw_got and w_got record them.
- Once both flags are set: go to WR_ISSUE, or go directly to BRESP if the captured wstrb == 0 (no PI1 op is issued).
- AR is accepted only while aw_got = w_got = 0.

**Arbitration (all in IDLE)**
- Contention means AR and (AW or W) valid in the same cycle.
- It is resolved round-robin, toggling on each granted contention. The first contention after reset goes to read.

**Issue and completion**
- WR_ISSUE / RD_ISSUE drive the op, address, data and sel until a cycle with pi1_rdy_i = 1 (the accept cycle), then go to WAIT.
- WAIT drives pi1_op_o = NOOP. The next cycle with pi1_rdy_i = 1 is the completion cycle; for reads, pi1_data_i is registered into axi4_rdata_o there.
- From WAIT: write → BRESP, read → RRESP.

**Responses**
- BRESP holds bvalid until bready, then returns to IDLE and clears the flags.
- RRESP does the same with rvalid / rready; rdata is held stable meanwhile.

**Address handling:** low byte-address bits are ignored (no unaligned or narrow split).

## Timing
**Ready signals**
- axi4_awready_o, axi4_wready_o and axi4_arready_o are combinational from state, flags, arbitration pointer and valids.
- All three are 0 while rst_i = 1 and outside IDLE.

**Reset values:** bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, pi1_op_o = NOOP, pi1_addr_o / pi1_data_o / pi1_sel_o = 0, flags = 0, state = IDLE.

**Latency, with pi1_rdy_i held at 1**
- Handshake at cycle 0 → op driven and accepted at cycle 1 → completion at cycle 2 → BVALID/RVALID at cycle 3.
- Each low cycle of pi1_rdy_i, in ISSUE or WAIT, adds one cycle.

**Boundary cases**
- Reset mid-transaction: returns to IDLE immediately and asynchronously; op goes to NOOP; no B/R response; flags cleared.
- AW arriving with W already held, or the reverse: accepted in IDLE the next cycle it is valid.
- bready / rready already high when valid rises: one-cycle response, IDLE the next cycle.

## Structure
- The PI1 op encodings (PINOOP/PIWROP/PIRDOP/PIRWOP) and clog2 come from the shared PI1 definitions include; they are not redefined locally.
- There is no sub-module: single FSM plus capture registers, about 150-200 lines.

## Test plan
- **Write:** AW addr 0x104 and W 0xDEADBEEF, strb 4'hF, same cycle, pi1_rdy_i = 1.
  - Cycle 1: pi1_op_o = 01, addr = 0x41, sel = 4'hF.
  - Cycle 3: BVALID with bresp = 00.
- **Read with slave stall:** AR 0x20, pi1_rdy_i low for 3 cycles in WAIT, pi1_data_i = 0x12345678 at completion.
  - RVALID with rdata = 0x12345678, 3 cycles later than nominal.
- **W before AW:** W at cycle 0, AW at cycle 4.
  - Exactly one PI1 write, issued at cycle 5.
- **Contention:** AR and AW+W valid together twice in a row.
  - First grant is the read, second the write; no AR accepted while aw_got = 1.
- **Zero strobe:** wstrb = 0.
  - No PI1 op; BVALID in the cycle after capture.
- **Reset in WAIT:** assert rst_i while in WAIT.
  - pi1_op_o = 00 in the same cycle; no BVALID; next AR is served normally.
